alu_mc: RTL

Parametrised, multi-cycle successor to the datapath ALU. It executes the full arithmetic, logic, shift/rotate, set-condition and bit-reverse set at any power-of-two width. It adds an optional iterative shift-add multiplier and places a single-entry registered output stage behind a valid/ready handshake. It sits between decode/register-read and writeback, so the execute stage can stall on long operations and on downstream backpressure.

---
 rtl/alu_mc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with registered valid/ready result stage
// Optional iterative shift-add multiplier compiled in when ALU_MUL_EN is defined.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             N,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] W_AMT = (SHW+1)'(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff, rol, ror, btr;
  logic             add_ofl, sub_ofl, slt;
  logic [WIDTH-1:0] res;
  logic             res_ofl, res_err;
  logic             accept;
  logic             load_en, load_ofl, load_err;
  logic [WIDTH-1:0] load_res;

  logic [WIDTH-1:0] out_q;
  logic             ofl_q, err_q, out_valid_q;

  assign shamt   = B[SHW-1:0];
  assign sum_ext = {1'b0, A} + {1'b0, B};
  assign diff    = A + ~B + WIDTH'(1);
  assign add_ofl = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
  assign sub_ofl = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  // Sign of A-B corrected by overflow gives a full-range signed compare.
  assign slt     = diff[WIDTH-1] ^ sub_ofl;
  assign rol     = (A << shamt) | (A >> (W_AMT - {1'b0, shamt}));
  assign ror     = (A >> shamt) | (A << (W_AMT - {1'b0, shamt}));

  always_comb begin
    btr = '0;
    for (int i = 0; i < WIDTH; i++) btr[i] = A[WIDTH-1-i];
  end

  always_comb begin
    res     = '0;
    res_ofl = 1'b0;
    res_err = 1'b0;
    case (op)
      4'd0:  begin res = sum_ext[WIDTH-1:0]; res_ofl = add_ofl; end
      4'd1:  begin res = diff; res_ofl = sub_ofl; end
      4'd2:  res = A ^ B;
      4'd3:  res = A & ~B;
      4'd4:  res = rol;
      4'd5:  res = A << shamt;
      4'd6:  res = ror;
      4'd7:  res = A >> shamt;
      4'd8:  res = {{(WIDTH-1){1'b0}}, (A == B)};
      4'd9:  res = {{(WIDTH-1){1'b0}}, slt};
      4'd10: res = {{(WIDTH-1){1'b0}}, (slt | (A == B))};
      4'd11: res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      4'd12: res = btr;
      default: res_err = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_next;
  logic [SHW:0]     cnt_q;
  logic             mul_start, mul_done;

  assign acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_start = accept && (op == 4'd13);
  assign mul_done  = (state_q == S_MUL) && (cnt_q == (SHW+1)'(WIDTH-1));
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL:  if (mul_done)  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        acc_q    <= '0;
        mcand_q  <= A;
        mplier_q <= B;
        cnt_q    <= '0;
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + (SHW+1)'(1);
      end
    end
  end

  // The final partial product is folded in on the completion edge.
  assign load_en  = (accept && (op != 4'd13)) || mul_done;
  assign load_res = mul_done ? acc_next : res;
  assign load_ofl = mul_done ? 1'b0 : res_ofl;
  assign load_err = mul_done ? 1'b0 : res_err;
`else
  assign in_ready = !out_valid_q || out_ready;
  assign load_en  = accept;
  assign load_res = res;
  assign load_ofl = res_ofl;
  assign load_err = res_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      ofl_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_q       <= load_res;
      ofl_q       <= load_ofl;
      err_q       <= load_err;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign Out       = out_q;
  assign Ofl       = ofl_q;
  assign err       = err_q;
  assign Z         = (out_q == '0);
  assign N         = out_q[WIDTH-1];
endmodule
